// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared widths, types and helpers for the register file scoreboard
package regfile_scoreboard_pkg;
  localparam int REG_WIDTH     = 16;
  localparam int VREG_WIDTH    = 64;
  localparam int OPCODE_WIDTH  = 8;
  localparam int REGFILE_DEPTH = 16;

  typedef logic [REG_WIDTH-1:0]     sreg_t;
  typedef logic [VREG_WIDTH-1:0]    vreg_t;
  typedef logic [REGFILE_DEPTH-1:0] mask_t;
  typedef logic [3:0]               ridx_t;

  function automatic mask_t idx_onehot(input ridx_t idx, input logic en);
    idx_onehot = en ? (mask_t'(1) << idx) : '0;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bus between the pipeline and the register file
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic       I_LOCK;
  logic       I_WriteBackEnable;
  logic [5:0] I_WriteBackRegIdx;
  sreg_t      I_WriteBackData;
  logic       I_VWriteBackEnable;
  vreg_t      I_VWriteBackData;
  ridx_t      I_Src1Idx, I_Src2Idx, I_VSrc1Idx, I_VSrc2Idx;
  logic       I_Src1Valid, I_Src2Valid, I_VSrc1Valid, I_VSrc2Valid;
  logic       I_IssueEnable;
  logic       I_IssueVector;
  ridx_t      I_IssueDestIdx;
  sreg_t      O_Src1Data, O_Src2Data;
  vreg_t      O_VSrc1Data, O_VSrc2Data;
  logic       O_DepStall;
  mask_t      O_BusyMask, O_VBusyMask;

  modport master (
    output I_LOCK, I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
           I_VWriteBackEnable, I_VWriteBackData,
           I_Src1Idx, I_Src2Idx, I_VSrc1Idx, I_VSrc2Idx,
           I_Src1Valid, I_Src2Valid, I_VSrc1Valid, I_VSrc2Valid,
           I_IssueEnable, I_IssueVector, I_IssueDestIdx,
    input  O_Src1Data, O_Src2Data, O_VSrc1Data, O_VSrc2Data,
           O_DepStall, O_BusyMask, O_VBusyMask
  );

  modport slave (
    input  I_LOCK, I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
           I_VWriteBackEnable, I_VWriteBackData,
           I_Src1Idx, I_Src2Idx, I_VSrc1Idx, I_VSrc2Idx,
           I_Src1Valid, I_Src2Valid, I_VSrc1Valid, I_VSrc2Valid,
           I_IssueEnable, I_IssueVector, I_IssueDestIdx,
    output O_Src1Data, O_Src2Data, O_VSrc1Data, O_VSrc2Data,
           O_DepStall, O_BusyMask, O_VBusyMask
  );
endinterface

// File: rtl/regfile_scoreboard_scoreboard.sv
// rtl/regfile_scoreboard_scoreboard.sv - scalar/vector busy masks and dependency stall
// Optional: REGFILE_WB_BYPASS_EN lets a same-cycle writeback release a RAW stall.
module regfile_scoreboard_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  lock,
  input  logic  wb_en,
  input  logic  vwb_en,
  input  ridx_t wb_idx,
  input  ridx_t src1_idx,
  input  ridx_t src2_idx,
  input  ridx_t vsrc1_idx,
  input  ridx_t vsrc2_idx,
  input  logic  src1_valid,
  input  logic  src2_valid,
  input  logic  vsrc1_valid,
  input  logic  vsrc2_valid,
  input  logic  issue_en,
  input  logic  issue_vec,
  input  ridx_t issue_idx,
  output logic  dep_stall,
  output mask_t busy_mask,
  output mask_t vbusy_mask
);
  mask_t busy_q, busy_d, vbusy_q, vbusy_d;
  mask_t clr, vclr, set, vset, busy_src, vbusy_src;
  logic  waw;

  always_comb begin
    clr  = idx_onehot(wb_idx, lock & wb_en);
    vclr = idx_onehot(wb_idx, lock & vwb_en);
`ifdef REGFILE_WB_BYPASS_EN
    busy_src  = busy_q & ~clr;
    vbusy_src = vbusy_q & ~vclr;
`else
    busy_src  = busy_q;
    vbusy_src = vbusy_q;
`endif
    // WAW always sees the registered mask; only source reads may be forwarded
    waw = issue_en & (issue_vec ? vbusy_q[issue_idx] : busy_q[issue_idx]);
    dep_stall = (src1_valid  & busy_src[src1_idx])
              | (src2_valid  & busy_src[src2_idx])
              | (vsrc1_valid & vbusy_src[vsrc1_idx])
              | (vsrc2_valid & vbusy_src[vsrc2_idx])
              | waw;
    set  = idx_onehot(issue_idx, lock & issue_en & ~issue_vec & ~dep_stall);
    vset = idx_onehot(issue_idx, lock & issue_en &  issue_vec & ~dep_stall);
    busy_d  = (busy_q  & ~clr)  | set;
    vbusy_d = (vbusy_q & ~vclr) | vset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      vbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      vbusy_q <= vbusy_d;
    end
  end

  assign busy_mask  = busy_q;
  assign vbusy_mask = vbusy_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 16 scalar + 16 vector registers with issue scoreboard
// Optional: REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic I_CLOCK,
  input  logic I_RESET_N,
  regfile_scoreboard_if.slave rf
);
  sreg_t regs_q  [REGFILE_DEPTH];
  sreg_t regs_d  [REGFILE_DEPTH];
  vreg_t vregs_q [REGFILE_DEPTH];
  vreg_t vregs_d [REGFILE_DEPTH];
  ridx_t wb_idx;
  logic  wr_s, wr_v, fwd_s, fwd_v;
  logic [1:0] unused_idx_bits;

  assign wb_idx          = rf.I_WriteBackRegIdx[3:0];
  assign unused_idx_bits = rf.I_WriteBackRegIdx[5:4];
  assign wr_s            = rf.I_LOCK & rf.I_WriteBackEnable;
  assign wr_v            = rf.I_LOCK & rf.I_VWriteBackEnable;

`ifdef REGFILE_WB_BYPASS_EN
  // Gated by reset so reads stay zero while the array is held cleared
  assign fwd_s = I_RESET_N & wr_s;
  assign fwd_v = I_RESET_N & wr_v;
`else
  assign fwd_s = 1'b0;
  assign fwd_v = 1'b0;
`endif

  always_comb begin
    regs_d  = regs_q;
    vregs_d = vregs_q;
    if (wr_s) regs_d[wb_idx]  = rf.I_WriteBackData;
    if (wr_v) vregs_d[wb_idx] = rf.I_VWriteBackData;
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < REGFILE_DEPTH; i++) begin
        regs_q[i]  <= '0;
        vregs_q[i] <= '0;
      end
    end else begin
      regs_q  <= regs_d;
      vregs_q <= vregs_d;
    end
  end

  assign rf.O_Src1Data  = (fwd_s && wb_idx == rf.I_Src1Idx)  ? rf.I_WriteBackData  : regs_q[rf.I_Src1Idx];
  assign rf.O_Src2Data  = (fwd_s && wb_idx == rf.I_Src2Idx)  ? rf.I_WriteBackData  : regs_q[rf.I_Src2Idx];
  assign rf.O_VSrc1Data = (fwd_v && wb_idx == rf.I_VSrc1Idx) ? rf.I_VWriteBackData : vregs_q[rf.I_VSrc1Idx];
  assign rf.O_VSrc2Data = (fwd_v && wb_idx == rf.I_VSrc2Idx) ? rf.I_VWriteBackData : vregs_q[rf.I_VSrc2Idx];

  regfile_scoreboard_scoreboard u_scoreboard (
    .clk         (I_CLOCK),
    .rst_n       (I_RESET_N),
    .lock        (rf.I_LOCK),
    .wb_en       (rf.I_WriteBackEnable),
    .vwb_en      (rf.I_VWriteBackEnable),
    .wb_idx      (wb_idx),
    .src1_idx    (rf.I_Src1Idx),
    .src2_idx    (rf.I_Src2Idx),
    .vsrc1_idx   (rf.I_VSrc1Idx),
    .vsrc2_idx   (rf.I_VSrc2Idx),
    .src1_valid  (rf.I_Src1Valid),
    .src2_valid  (rf.I_Src2Valid),
    .vsrc1_valid (rf.I_VSrc1Valid),
    .vsrc2_valid (rf.I_VSrc2Valid),
    .issue_en    (rf.I_IssueEnable),
    .issue_vec   (rf.I_IssueVector),
    .issue_idx   (rf.I_IssueDestIdx),
    .dep_stall   (rf.O_DepStall),
    .busy_mask   (rf.O_BusyMask),
    .vbusy_mask  (rf.O_VBusyMask)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  regfile_scoreboard_if rf();

  regfile_scoreboard dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .rf        (rf)
  );

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic idle();
    rf.I_LOCK = 1'b1;
    rf.I_WriteBackEnable = 1'b0;
    rf.I_WriteBackRegIdx = '0;
    rf.I_WriteBackData = '0;
    rf.I_VWriteBackEnable = 1'b0;
    rf.I_VWriteBackData = '0;
    rf.I_Src1Idx = '0;  rf.I_Src2Idx = '0;
    rf.I_VSrc1Idx = '0; rf.I_VSrc2Idx = '0;
    rf.I_Src1Valid = 1'b0;  rf.I_Src2Valid = 1'b0;
    rf.I_VSrc1Valid = 1'b0; rf.I_VSrc2Valid = 1'b0;
    rf.I_IssueEnable = 1'b0;
    rf.I_IssueVector = 1'b0;
    rf.I_IssueDestIdx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd3; rf.I_WriteBackData = 16'hFFFF;
    rf.I_Src1Idx = 4'd3;
    #2;
    sb.push_back(64'h0); chk("rst_busy", 64'(rf.O_BusyMask));
    sb.push_back(64'h0); chk("rst_vbusy", 64'(rf.O_VBusyMask));
    sb.push_back(64'h0); chk("rst_stall", 64'(rf.O_DepStall));
    sb.push_back(64'h0); chk("rst_src1", 64'(rf.O_Src1Data));
    step();
    sb.push_back(64'h0); chk("rst_write_discard", 64'(rf.O_Src1Data));
    @(negedge clk);
    rst_n = 1'b1;

    // scalar write R3, first edge after release
    idle();
    rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd3; rf.I_WriteBackData = 16'h1234;
    step();
    idle(); rf.I_Src1Idx = 4'd3; rf.I_Src2Idx = 4'd4; #1;
    sb.push_back(64'h1234); chk("wr_r3", 64'(rf.O_Src1Data));
    sb.push_back(64'h0);    chk("r4_unchanged", 64'(rf.O_Src2Data));

    // upper index bits ignored: 6'h3A targets R10
    rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'h3A; rf.I_WriteBackData = 16'hA5A5;
    step();
    idle(); rf.I_Src1Idx = 4'd10; #1;
    sb.push_back(64'hA5A5); chk("idx_high_ignored", 64'(rf.O_Src1Data));

    // RAW on R5
    rf.I_IssueEnable = 1'b1; rf.I_IssueDestIdx = 4'd5; #1;
    sb.push_back(64'h0); chk("issue_r5_nostall", 64'(rf.O_DepStall));
    step();
    idle(); #1;
    sb.push_back(64'h0020); chk("busy_r5", 64'(rf.O_BusyMask));
    rf.I_IssueEnable = 1'b1; rf.I_IssueDestIdx = 4'd5; #1;
    sb.push_back(64'h1); chk("waw_stall_r5", 64'(rf.O_DepStall));
    rf.I_IssueEnable = 1'b0; rf.I_Src1Idx = 4'd5; rf.I_Src1Valid = 1'b1; #1;
    sb.push_back(64'h1); chk("raw_stall_r5", 64'(rf.O_DepStall));
    step();
    sb.push_back(64'h1);    chk("raw_stall_hold", 64'(rf.O_DepStall));
    sb.push_back(64'h0020); chk("busy_r5_hold", 64'(rf.O_BusyMask));
    rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd5; rf.I_WriteBackData = 16'h5555; #1;
`ifdef REGFILE_WB_BYPASS_EN
    sb.push_back(64'h0);    chk("raw_wb_cycle_stall", 64'(rf.O_DepStall));
    sb.push_back(64'h5555); chk("raw_wb_cycle_data", 64'(rf.O_Src1Data));
`else
    sb.push_back(64'h1);    chk("raw_wb_cycle_stall", 64'(rf.O_DepStall));
    sb.push_back(64'h0);    chk("raw_wb_cycle_data", 64'(rf.O_Src1Data));
`endif
    step();
    idle(); rf.I_Src1Idx = 4'd5; rf.I_Src1Valid = 1'b1; #1;
    sb.push_back(64'h0);    chk("raw_after_stall", 64'(rf.O_DepStall));
    sb.push_back(64'h5555); chk("raw_after_data", 64'(rf.O_Src1Data));
    sb.push_back(64'h0);    chk("raw_after_busy", 64'(rf.O_BusyMask));

    // same-cycle issue and writeback of V2
    idle();
    rf.I_IssueEnable = 1'b1; rf.I_IssueVector = 1'b1; rf.I_IssueDestIdx = 4'd2;
    rf.I_VWriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd2;
    rf.I_VWriteBackData = 64'hDEAD_BEEF_0000_0001; #1;
    sb.push_back(64'h0); chk("v2_issue_nostall", 64'(rf.O_DepStall));
    step();
    idle(); rf.I_VSrc1Idx = 4'd2; #1;
    sb.push_back(64'h0004); chk("v2_busy_kept", 64'(rf.O_VBusyMask));
    sb.push_back(64'hDEAD_BEEF_0000_0001); chk("v2_new_data", rf.O_VSrc1Data);
    rf.I_VSrc1Valid = 1'b1; #1;
    sb.push_back(64'h1); chk("v2_raw_stall", 64'(rf.O_DepStall));

    // dual write R1 and V1 after issuing both
    idle(); rf.I_IssueEnable = 1'b1; rf.I_IssueDestIdx = 4'd1;
    step();
    idle(); rf.I_IssueEnable = 1'b1; rf.I_IssueVector = 1'b1; rf.I_IssueDestIdx = 4'd1;
    step();
    idle(); #1;
    sb.push_back(64'h0002); chk("dual_busy_pre", 64'(rf.O_BusyMask));
    sb.push_back(64'h0006); chk("dual_vbusy_pre", 64'(rf.O_VBusyMask));
    rf.I_WriteBackEnable = 1'b1; rf.I_VWriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd1;
    rf.I_WriteBackData = 16'h00FF; rf.I_VWriteBackData = 64'h1;
    step();
    idle(); rf.I_Src1Idx = 4'd1; rf.I_VSrc2Idx = 4'd1; #1;
    sb.push_back(64'h00FF); chk("dual_r1", 64'(rf.O_Src1Data));
    sb.push_back(64'h1);    chk("dual_v1", rf.O_VSrc2Data);
    sb.push_back(64'h0);    chk("dual_busy_post", 64'(rf.O_BusyMask));
    sb.push_back(64'h0004); chk("dual_vbusy_post", 64'(rf.O_VBusyMask));

    // lock low: everything ignored, reads live
    idle(); rf.I_LOCK = 1'b0;
    rf.I_WriteBackEnable = 1'b1; rf.I_VWriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd7;
    rf.I_WriteBackData = 16'h7777; rf.I_VWriteBackData = 64'h7777_7777_7777_7777;
    rf.I_IssueEnable = 1'b1; rf.I_IssueDestIdx = 4'd8;
    rf.I_Src2Idx = 4'd3; #1;
    sb.push_back(64'h1234); chk("lock0_read_live", 64'(rf.O_Src2Data));
    step();
    idle(); rf.I_Src1Idx = 4'd7; rf.I_VSrc1Idx = 4'd7; #1;
    sb.push_back(64'h0);    chk("lock0_r7", 64'(rf.O_Src1Data));
    sb.push_back(64'h0);    chk("lock0_v7", rf.O_VSrc1Data);
    sb.push_back(64'h0);    chk("lock0_busy", 64'(rf.O_BusyMask));
    sb.push_back(64'h0004); chk("lock0_vbusy", 64'(rf.O_VBusyMask));

    // reset mid-run between edges
    idle(); rf.I_Src1Idx = 4'd3; rf.I_VSrc1Idx = 4'd2; rf.I_VSrc1Valid = 1'b1;
    rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd3; rf.I_WriteBackData = 16'h9999; #1;
    sb.push_back(64'h1); chk("pre_rst_stall", 64'(rf.O_DepStall));
    rst_n = 1'b0; #1;
    sb.push_back(64'h0); chk("midrst_src1", 64'(rf.O_Src1Data));
    sb.push_back(64'h0); chk("midrst_vsrc1", rf.O_VSrc1Data);
    sb.push_back(64'h0); chk("midrst_vbusy", 64'(rf.O_VBusyMask));
    sb.push_back(64'h0); chk("midrst_stall", 64'(rf.O_DepStall));
    step();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); rf.I_WriteBackEnable = 1'b1; rf.I_WriteBackRegIdx = 6'd9; rf.I_WriteBackData = 16'h0909;
    step();
    idle(); rf.I_Src1Idx = 4'd9; rf.I_Src2Idx = 4'd3; #1;
    sb.push_back(64'h0909); chk("post_rst_first_write", 64'(rf.O_Src1Data));
    sb.push_back(64'h0);    chk("post_rst_r3_cleared", 64'(rf.O_Src2Data));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
